// File: rtl/demosaic_frame_seq_if.sv
// demosaic_frame_seq_if: control/status bundle between the frame sequencer and its environment (BORDER present under DEMOSAIC_FRAME_SEQ_BORDER_EN)
interface demosaic_frame_seq_if #(parameter int CNT_W = 20);
  logic start_i, stall_i, out_valid_i;
  logic rd_en_o, out_en_o, busy_o, done_o, err_o;
  logic [CNT_W-1:0] rd_addr_o, row_o, col_o, out_cnt_o;
`ifdef DEMOSAIC_FRAME_SEQ_BORDER_EN
  logic border_o;
  modport master(output start_i, stall_i, out_valid_i,
                 input rd_en_o, out_en_o, busy_o, done_o, err_o, rd_addr_o, row_o, col_o, out_cnt_o, border_o);
  modport slave(input start_i, stall_i, out_valid_i,
                output rd_en_o, out_en_o, busy_o, done_o, err_o, rd_addr_o, row_o, col_o, out_cnt_o, border_o);
`else
  modport master(output start_i, stall_i, out_valid_i,
                 input rd_en_o, out_en_o, busy_o, done_o, err_o, rd_addr_o, row_o, col_o, out_cnt_o);
  modport slave(input start_i, stall_i, out_valid_i,
                output rd_en_o, out_en_o, busy_o, done_o, err_o, rd_addr_o, row_o, col_o, out_cnt_o);
`endif
endinterface

// File: rtl/demosaic_frame_seq.sv
// demosaic_frame_seq: raster read sequencer and output gate for one Bayer frame; DEMOSAIC_FRAME_SEQ_BORDER_EN adds the BORDER flag
module demosaic_frame_seq #(
  parameter int WIDTH   = 512,
  parameter int HEIGHT  = 768,
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 1024
) (
  input logic INCLK,
  input logic RSTN,
  demosaic_frame_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_FEED = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(WIDTH * HEIGHT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH * HEIGHT - 1);
  localparam logic [CNT_W-1:0] COL_L = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_L = CNT_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);
  localparam logic [TW-1:0] TONE = TW'(1);

  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] p_addr_q, p_addr_d, p_row_q, p_row_d, p_col_q, p_col_d;
  logic [CNT_W-1:0] addr_q, addr_d, row_q, row_d, col_q, col_d, cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic rd_en_q, err_q, err_d, full_d, tmo_hit;
  logic go, busy, issue, out_en, wrap;
`ifdef DEMOSAIC_FRAME_SEQ_BORDER_EN
  logic border_q, border_d;
`endif

  assign go     = state_q == S_IDLE && bus.start_i;
  assign busy   = state_q == S_FEED || state_q == S_DRAIN;
  assign issue  = state_q == S_FEED && !bus.stall_i;
  assign out_en = busy && bus.out_valid_i && cnt_q != TOTAL;
  assign wrap   = p_col_q == COL_L;

  // Next-state: read pointer walks the raster, output regs latch the issued position, counters and FSM advance
  always_comb begin
    cnt_d    = go ? '0 : cnt_q + CNT_W'(out_en);
    full_d   = cnt_d == TOTAL;
    tmo_d    = (state_q == S_DRAIN && !bus.out_valid_i) ? tmo_q + TONE : '0;
    tmo_hit  = tmo_d == TMO;
    p_addr_d = go ? '0 : issue ? p_addr_q + ONE : p_addr_q;
    p_col_d  = go ? '0 : issue ? (wrap ? '0 : p_col_q + ONE) : p_col_q;
    p_row_d  = go ? '0 : (issue && wrap) ? p_row_q + ONE : p_row_q;
    addr_d   = go ? '0 : issue ? p_addr_q : addr_q;
    row_d    = go ? '0 : issue ? p_row_q : row_q;
    col_d    = go ? '0 : issue ? p_col_q : col_q;
    err_d    = go ? 1'b0 : err_q | (busy && bus.out_valid_i && !out_en) | (state_q == S_DRAIN && !full_d && tmo_hit);
    state_d  = (state_q == S_IDLE)  ? (go ? S_FEED : S_IDLE)
             : (state_q == S_FEED)  ? ((issue && p_addr_q == LAST) ? (full_d ? S_DONE : S_DRAIN) : S_FEED)
             : (state_q == S_DRAIN) ? ((full_d || tmo_hit) ? S_DONE : S_DRAIN)
             : S_IDLE;
`ifdef DEMOSAIC_FRAME_SEQ_BORDER_EN
    border_d = issue && (p_row_q == '0 || p_row_q == ROW_L || p_col_q == '0 || wrap);
`endif
  end

  // State registers; reset aborts any frame in flight without a DONE pulse
  always_ff @(posedge INCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= S_IDLE;
      p_addr_q <= '0;
      p_row_q  <= '0;
      p_col_q  <= '0;
      addr_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      rd_en_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef DEMOSAIC_FRAME_SEQ_BORDER_EN
      border_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      p_addr_q <= p_addr_d;
      p_row_q  <= p_row_d;
      p_col_q  <= p_col_d;
      addr_q   <= addr_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      rd_en_q  <= issue;
      err_q    <= err_d;
`ifdef DEMOSAIC_FRAME_SEQ_BORDER_EN
      border_q <= border_d;
`endif
    end
  end

  assign bus.rd_en_o   = rd_en_q;
  assign bus.rd_addr_o = addr_q;
  assign bus.row_o     = row_q;
  assign bus.col_o     = col_q;
  assign bus.out_en_o  = out_en;
  assign bus.out_cnt_o = cnt_q;
  assign bus.busy_o    = busy;
  assign bus.done_o    = state_q == S_DONE;
  assign bus.err_o     = err_q;
`ifdef DEMOSAIC_FRAME_SEQ_BORDER_EN
  assign bus.border_o  = border_q;
`endif
endmodule

// File: doc/demosaic_frame_seq.md
Name: demosaic_frame_seq

Overview:
Frame sequencer for the demosaic datapath. On START it raster-scans one Bayer frame, issuing source read strobes and addresses with row/column position. It counts pixels returned by the pipeline and gates them to the result writer (IN_EN/DATA of the writeback stage). When the last pixel lands it pulses DONE, and it flags errors for stalls and over-delivery.

Parameters:
WIDTH, 512, pixels per row
HEIGHT, 768, rows per frame
CNT_W, 20, width of pixel counters/address; must satisfy 2^CNT_W > WIDTH*HEIGHT
TIMEOUT, 1024, max idle cycles in DRAIN without OUT_VALID before ERR

Ports:
INCLK  in  1  clock, all logic on rising edge
RSTN  in  1  asynchronous active-low reset
START  in  1  begin a frame; sampled only in IDLE
STALL  in  1  downstream not ready; freezes read issue
RD_EN  out  1  read strobe to Bayer source, one pixel per cycle
RD_ADDR  out  CNT_W  linear pixel address row*WIDTH+col
ROW  out  CNT_W  row of current RD_ADDR
COL  out  CNT_W  column of current RD_ADDR
OUT_VALID  in  1  demosaic pipeline output strobe
OUT_EN  out  1  write enable to result writer
OUT_CNT  out  CNT_W  pixels delivered this frame
BUSY  out  1  high in FEED and DRAIN
DONE  out  1  one-cycle pulse at frame completion
ERR  out  1  sticky error, cleared by reset or next accepted START

Behaviour:
- Reset (async, RSTN=0): state IDLE; RD_EN=0, RD_ADDR=ROW=COL=0, OUT_EN=0, OUT_CNT=0, BUSY=0, DONE=0, ERR=0; timeout counter 0. Mid-frame reset aborts immediately, with no DONE.
- TOTAL = WIDTH*HEIGHT.
- IDLE: START=1 -> FEED next cycle; clears RD_ADDR/ROW/COL/OUT_CNT/ERR.
- FEED: RD_EN = !STALL (registered, asserted the cycle after the decision). Each issued read advances COL. At COL=WIDTH-1 it wraps COL to 0 and increments ROW. RD_ADDR increments by 1 per issued read. On the read with RD_ADDR=TOTAL-1 -> DRAIN. RD_ADDR/ROW/COL hold while STALL=1.
- DRAIN: RD_EN=0. The timeout counter increments each cycle without OUT_VALID and resets on OUT_VALID. Reaching TIMEOUT sets ERR and moves to DONE.
- OUT_VALID handling (FEED and DRAIN): OUT_EN = OUT_VALID combinationally passed when OUT_CNT<TOTAL, and OUT_CNT increments. When OUT_CNT=TOTAL, OUT_VALID is dropped (OUT_EN=0) and ERR is set.
- DRAIN -> DONE when OUT_CNT reaches TOTAL, including the cycle it is incremented to TOTAL. OUT_VALID may reach TOTAL while still in FEED; in that case go to DONE after the last read.
- DONE state: DONE=1 for exactly one cycle, BUSY=0, -> IDLE. OUT_CNT holds its final value until the next START.
- START while BUSY: ignored, and ERR is unaffected.
- STALL does not block OUT_EN; the writer is assumed always ready.
- Counters saturate-free: widths are guaranteed by the CNT_W constraint.

Optional Feature:
Macro DEMOSAIC_FRAME_SEQ_BORDER_EN.
- Defined: adds output BORDER (1 bit), registered alongside RD_EN, high when ROW=0, ROW=HEIGHT-1, COL=0 or COL=WIDTH-1 for the issued address. BORDER is 0 whenever RD_EN=0 and at reset. The demosaic interpolator uses it for edge replication.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=4, HEIGHT=3, START pulse, STALL=0, OUT_VALID echoing RD_EN delayed 4 cycles -> 12 RD_EN pulses; RD_ADDR 0..11 with COL wrapping 3->0 at addresses 4 and 8; OUT_CNT=12; DONE pulses once ~5 cycles after last read; ERR=0.
- Same frame with STALL high for 3 cycles at address 5 -> RD_ADDR holds 5 for 3 cycles with RD_EN=0; total reads still 12; no duplicated or skipped address.
- Pipeline returns only 11 pixels, TIMEOUT=16 -> ERR=1 and DONE 16 cycles after the last OUT_VALID; OUT_CNT=11.
- 13 OUT_VALID pulses -> 13th gives OUT_EN=0, ERR=1, OUT_CNT stays 12.
- RSTN low at RD_ADDR=6 -> all outputs 0 asynchronously, no DONE. The next START restarts cleanly from address 0.
- START asserted during FEED -> ignored, frame completes normally. With BORDER_EN: BORDER=1 for addresses 0-4, 7, 8-11 and 0 for addresses 5 and 6.
